// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: micro-op and immediate encodings,
// entry layout and the wakeup merge helper.
package uopc;
  typedef enum logic [4:0] {
    UOP_NOP  = 5'd0,
    UOP_ADD,
    UOP_ADDI,
    UOP_SUB,
    UOP_AND,
    UOP_OR,
    UOP_XOR,
    UOP_SLL,
    UOP_SRL,
    UOP_SRA,
    UOP_SLT,
    UOP_LUI,
    UOP_AUIPC,
    UOP_BEQ,
    UOP_BNE,
    UOP_BLT,
    UOP_BGE,
    UOP_JAL,
    UOP_JALR
  } micro_opcode_t;
endpackage

package immt;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_Z
  } imm_type_t;
endpackage

package alu_issue_queue_pkg;
  localparam int IQ_PTAG_W = 6;
  localparam int IQ_ROB_W  = 4;
  localparam int IQ_IMM_W  = 20;

  // Entry storage is sized by these constants; the queue parameters must match.
  typedef struct packed {
    uopc::micro_opcode_t  uopcode;
    logic [IQ_IMM_W-1:0]  imm;
    immt::imm_type_t      imm_type;
    logic [IQ_PTAG_W-1:0] prs1;
    logic [IQ_PTAG_W-1:0] prs2;
    logic                 rdy1;
    logic                 rdy2;
    logic [IQ_PTAG_W-1:0] pdst;
    logic [IQ_ROB_W-1:0]  rob;
  } iq_entry_t;

  function automatic iq_entry_t iq_wake(input iq_entry_t e, input logic hit1, input logic hit2);
    iq_entry_t r;
    r      = e;
    r.rdy1 = e.rdy1 | hit1;
    r.rdy2 = e.rdy2 | hit2;
    return r;
  endfunction
endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch-side enqueue and RRD-side issue bundle of the ALU issue queue.
interface alu_issue_queue_if import alu_issue_queue_pkg::*; #(
  parameter int PTAG_W = IQ_PTAG_W,
  parameter int ROB_W  = IQ_ROB_W
) ();
  logic                 enq_valid;
  logic                 enq_ready;
  uopc::micro_opcode_t  enq_uopcode;
  logic [IQ_IMM_W-1:0]  enq_imm;
  immt::imm_type_t      enq_imm_type;
  logic [PTAG_W-1:0]    enq_prs1;
  logic [PTAG_W-1:0]    enq_prs2;
  logic                 enq_rs1_rdy;
  logic                 enq_rs2_rdy;
  logic [PTAG_W-1:0]    enq_pdst;
  logic [ROB_W-1:0]     enq_rob;

  logic                 iss_valid;
  logic                 iss_ready;
  uopc::micro_opcode_t  iss_uopcode;
  logic [IQ_IMM_W-1:0]  iss_imm;
  immt::imm_type_t      iss_imm_type;
  logic [PTAG_W-1:0]    iss_prs1;
  logic [PTAG_W-1:0]    iss_prs2;
  logic [PTAG_W-1:0]    iss_pdst;
  logic [ROB_W-1:0]     iss_rob;

  modport master (
    output enq_valid, enq_uopcode, enq_imm, enq_imm_type, enq_prs1, enq_prs2,
           enq_rs1_rdy, enq_rs2_rdy, enq_pdst, enq_rob, iss_ready,
    input  enq_ready, iss_valid, iss_uopcode, iss_imm, iss_imm_type, iss_prs1,
           iss_prs2, iss_pdst, iss_rob
  );

  modport slave (
    input  enq_valid, enq_uopcode, enq_imm, enq_imm_type, enq_prs1, enq_prs2,
           enq_rs1_rdy, enq_rs2_rdy, enq_pdst, enq_rob, iss_ready,
    output enq_ready, iss_valid, iss_uopcode, iss_imm, iss_imm_type, iss_prs1,
           iss_prs2, iss_pdst, iss_rob
  );
endinterface

// File: rtl/alu_issue_queue_wakeup_cam.sv
// Matches one source tag against every writeback broadcast port (OR of hits).
module iq_wakeup_cam import alu_issue_queue_pkg::*; #(
  parameter int PTAG_W     = IQ_PTAG_W,
  parameter int WAKE_PORTS = 2
) (
  input  logic [PTAG_W-1:0]                 tag,
  input  logic [WAKE_PORTS-1:0]             wake_valid,
  input  logic [WAKE_PORTS-1:0][PTAG_W-1:0] wake_tag,
  output logic                              hit
);
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wake_valid[p] && (wake_tag[p] == tag)) hit = 1'b1;
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered issue queue: holds renamed ALU/branch micro-ops until
// both sources are ready and issues the oldest ready entry each cycle.
module alu_issue_queue import alu_issue_queue_pkg::*; #(
  parameter int DEPTH      = 8,
  parameter int PTAG_W     = IQ_PTAG_W,
  parameter int ROB_W      = IQ_ROB_W,
  parameter int WAKE_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [WAKE_PORTS-1:0]             wake_valid,
  input  logic [WAKE_PORTS-1:0][PTAG_W-1:0] wake_tag,
  alu_issue_queue_if.slave                  iq,
  output logic [$clog2(DEPTH+1)-1:0]        count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        ent   [DEPTH];
  iq_entry_t        woken [DEPTH];
  iq_entry_t        nxt   [DEPTH];
  iq_entry_t        new_e;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wpos;
  logic [DEPTH-1:0] hit1, hit2, cand;
  logic             new_hit1, new_hit2;
  logic [IDX_W-1:0] sel;
  logic             iss_valid, enq_ok, do_iss, do_enq;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    iq_wakeup_cam #(.PTAG_W(PTAG_W), .WAKE_PORTS(WAKE_PORTS)) u_cam1 (
      .tag(ent[g].prs1), .wake_valid(wake_valid), .wake_tag(wake_tag), .hit(hit1[g]));
    iq_wakeup_cam #(.PTAG_W(PTAG_W), .WAKE_PORTS(WAKE_PORTS)) u_cam2 (
      .tag(ent[g].prs2), .wake_valid(wake_valid), .wake_tag(wake_tag), .hit(hit2[g]));
  end

  iq_wakeup_cam #(.PTAG_W(PTAG_W), .WAKE_PORTS(WAKE_PORTS)) u_new_cam1 (
    .tag(iq.enq_prs1), .wake_valid(wake_valid), .wake_tag(wake_tag), .hit(new_hit1));
  iq_wakeup_cam #(.PTAG_W(PTAG_W), .WAKE_PORTS(WAKE_PORTS)) u_new_cam2 (
    .tag(iq.enq_prs2), .wake_valid(wake_valid), .wake_tag(wake_tag), .hit(new_hit2));

  // Selection reads registered ready bits only, so a wakeup never issues in its own cycle.
  always_comb begin
    cand = '0;
    sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = (CNT_W'(i) < cnt) && ent[i].rdy1 && ent[i].rdy2;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) sel = IDX_W'(i);
    end
  end

  assign iss_valid = |cand;
  assign enq_ok    = (cnt != CNT_W'(DEPTH));
  assign do_iss    = iss_valid && iq.iss_ready && !flush;
  assign do_enq    = iq.enq_valid && enq_ok && !flush;
  assign wpos      = do_iss ? (cnt - 1'b1) : cnt;

  always_comb begin
    new_e          = '0;
    new_e.uopcode  = iq.enq_uopcode;
    new_e.imm      = iq.enq_imm;
    new_e.imm_type = iq.enq_imm_type;
    new_e.prs1     = iq.enq_prs1;
    new_e.prs2     = iq.enq_prs2;
    new_e.rdy1     = iq.enq_rs1_rdy || (iq.enq_prs1 == '0) || new_hit1;
    new_e.rdy2     = iq.enq_rs2_rdy || (iq.enq_prs2 == '0) || new_hit2;
    new_e.pdst     = iq.enq_pdst;
    new_e.rob      = iq.enq_rob;
  end

  // Per-index collapse mux: hold, take the neighbour above, or take the arrival.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = iq_wake(ent[i], hit1[i], hit2[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = woken[i];
      if (do_iss && (IDX_W'(i) >= sel)) nxt[i] = woken[(i == DEPTH - 1) ? i : i + 1];
      if (do_enq && (CNT_W'(i) == wpos)) nxt[i] = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].rdy1 <= 1'b0;
        ent[i].rdy2 <= 1'b0;
      end
    end else begin
      if (flush) cnt <= '0;
      else       cnt <= cnt + CNT_W'(do_enq) - CNT_W'(do_iss);
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= nxt[i];
      end
    end
  end

  assign count         = cnt;
  assign iq.enq_ready  = enq_ok;
  assign iq.iss_valid  = iss_valid;
  assign iq.iss_uopcode  = iss_valid ? ent[sel].uopcode  : uopc::UOP_NOP;
  assign iq.iss_imm      = iss_valid ? ent[sel].imm      : '0;
  assign iq.iss_imm_type = iss_valid ? ent[sel].imm_type : immt::IMM_I;
  assign iq.iss_prs1     = iss_valid ? ent[sel].prs1     : '0;
  assign iq.iss_prs2     = iss_valid ? ent[sel].prs2     : '0;
  assign iq.iss_pdst     = iss_valid ? ent[sel].pdst     : '0;
  assign iq.iss_rob      = iss_valid ? ent[sel].rob      : '0;
endmodule
